// File: rtl/btn_conditioner.sv
// Per-button conditioner: 2-FF synchroniser, consecutive-sample debounce,
// registered level plus one-cycle press / release / auto-repeat pulses.
module btn_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] raw_btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat,
    output logic             any_press
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // Counters stop one short of the target: the increment that would reach it fires instead.
    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } rpt_state_t;

    logic [N_BTN-1:0] press_acc_s;
    logic             any_press_r;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [1:0]       sync_r;
        logic [DB_W-1:0]  db_cnt_r;
        logic             level_r;
        logic             press_r;
        logic             release_r;
        logic             sample_s;
        logic             accept_s;
        logic             release_acc_s;
        rpt_state_t       state_r;
        logic [RPT_W-1:0] rpt_cnt_r;
        logic             repeat_r;

        assign sample_s       = ~sync_r[1];
        assign accept_s       = (sample_s != level_r) && (db_cnt_r == DB_LAST);
        assign press_acc_s[i] = accept_s & sample_s;
        assign release_acc_s  = accept_s & ~sample_s;

        assign btn_level[i]   = level_r;
        assign btn_press[i]   = press_r;
        assign btn_release[i] = release_r;
        assign btn_repeat[i]  = repeat_r;

        // Two-stage synchroniser for the asynchronous active-low key.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_r <= 2'b11;
            end else begin
                sync_r <= {sync_r[0], raw_btn_n[i]};
            end
        end

        // Debounce counter and stable level with the matching edge pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt_r  <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
                if (sample_s == level_r) begin
                    db_cnt_r <= '0;
                end else if (accept_s) begin
                    db_cnt_r  <= '0;
                    level_r   <= sample_s;
                    press_r   <= sample_s;
                    release_r <= ~sample_s;
                end else begin
                    db_cnt_r <= db_cnt_r + DB_W'(1);
                end
            end
        end

        // Auto-repeat FSM; an accepted release wins over a coincident repeat.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_r   <= RELEASED;
                rpt_cnt_r <= '0;
                repeat_r  <= 1'b0;
            end else begin
                repeat_r <= 1'b0;
                if (release_acc_s) begin
                    state_r   <= RELEASED;
                    rpt_cnt_r <= '0;
                end else begin
                    case (state_r)
                        RELEASED: begin
                            rpt_cnt_r <= '0;
                            if (press_acc_s[i]) begin
                                state_r <= HELD_DELAY;
                            end else begin
                                state_r <= RELEASED;
                            end
                        end
                        HELD_DELAY: begin
                            if (rpt_cnt_r == DELAY_LAST) begin
                                state_r   <= HELD_REPEAT;
                                rpt_cnt_r <= '0;
                                repeat_r  <= 1'b1;
                            end else begin
                                rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
                            end
                        end
                        HELD_REPEAT: begin
                            if (rpt_cnt_r == PERIOD_LAST) begin
                                rpt_cnt_r <= '0;
                                repeat_r  <= 1'b1;
                            end else begin
                                rpt_cnt_r <= rpt_cnt_r + RPT_W'(1);
                            end
                        end
                        default: begin
                            state_r   <= RELEASED;
                            rpt_cnt_r <= '0;
                        end
                    endcase
                end
            end
        end
    end

    // Summary press flag, registered in the same cycle as the per-button pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            any_press_r <= 1'b0;
        end else begin
            any_press_r <= |press_acc_s;
        end
    end

    assign any_press = any_press_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (N_BTN=2, debounce 4, delay 6, period 3).
module tb_btn_conditioner;

    logic       clk;
    logic       reset;
    logic [1:0] raw_btn_n;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_repeat;
    logic       any_press;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] rpt;
        logic [1:0] lvl;
        logic       anyp;
    } exp_t;

    exp_t exp_q[$];

    btn_conditioner #(
        .N_BTN(2),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(6),
        .REPEAT_PERIOD(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw_btn_n(raw_btn_n),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_repeat(btn_repeat),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int c, input logic [1:0] p, input logic [1:0] r,
                                 input logic [1:0] rp, input logic [1:0] l, input logic a);
        exp_t e;
        e.cyc = c; e.press = p; e.rel = r; e.rpt = rp; e.lvl = l; e.anyp = a;
        exp_q.push_back(e);
    endfunction

    // Monitor: pops an expectation whenever the DUT presents a pulse; flags missed ones.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_event: no pulse at cycle %0d, required press=%b release=%b repeat=%b",
                         exp_q[0].cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].rpt);
                void'(exp_q.pop_front());
            end
            if ((btn_press | btn_release | btn_repeat) != 2'b00 || any_press) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: cycle %0d press=%b release=%b repeat=%b any=%b, required none",
                             cyc, btn_press, btn_release, btn_repeat, any_press);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.press != btn_press || e.rel != btn_release ||
                        e.rpt != btn_repeat || e.lvl != btn_level || e.anyp != any_press) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d press=%b release=%b repeat=%b level=%b any=%b, required cyc=%0d press=%b release=%b repeat=%b level=%b any=%b",
                                 cyc, btn_press, btn_release, btn_repeat, btn_level, any_press,
                                 e.cyc, e.press, e.rel, e.rpt, e.lvl, e.anyp);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat, any_press} != 9'd0) begin
            errors++;
            $display("FAIL %s: level=%b press=%b release=%b repeat=%b any=%b, required all 0",
                     name, btn_level, btn_press, btn_release, btn_repeat, any_press);
        end
    endtask

    initial begin
        int c;
        int p;
        int d0;
        reset     = 1'b1;
        raw_btn_n = 2'b11;
        tick(3);
        check_outputs_zero("reset_state");
        reset = 1'b0;
        tick(5);

        // Clean press on button 0, auto-repeat, release landing on a repeat slot.
        c = cyc;
        p = c + 6;
        push(p, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        for (int k = 0; k < 6; k++) push(p + 6 + 3 * k, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0);
        push(p + 24, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        raw_btn_n = 2'b10;
        tick(24);
        raw_btn_n = 2'b11;
        tick(12);
        check_drained("clean_repeat_release");

        // Glitch rejection: 3-cycle low, then bursts of 1, 2, 3.
        raw_btn_n = 2'b10; tick(3);
        raw_btn_n = 2'b11; tick(4);
        raw_btn_n = 2'b10; tick(1);
        raw_btn_n = 2'b11; tick(1);
        raw_btn_n = 2'b10; tick(2);
        raw_btn_n = 2'b11; tick(1);
        raw_btn_n = 2'b10; tick(3);
        raw_btn_n = 2'b11; tick(10);
        checks++;
        if (btn_level != 2'b00) begin
            errors++;
            $display("FAIL glitch_level: level=%b, required 00", btn_level);
        end
        check_drained("glitch_no_events");

        // Both buttons pressed together, then reset while in the repeat phase.
        c = cyc;
        p = c + 6;
        push(p, 2'b11, 2'b00, 2'b00, 2'b11, 1'b1);
        for (int k = 0; k < 3; k++) push(p + 6 + 3 * k, 2'b00, 2'b00, 2'b11, 2'b11, 1'b0);
        raw_btn_n = 2'b00;
        tick(19);
        #2;
        reset     = 1'b1;
        raw_btn_n = 2'b10;
        #1;
        check_outputs_zero("reset_mid_hold");
        check_drained("before_reset");
        tick(3);
        reset = 1'b0;

        // Button 0 held through reset: new press, restarted repeats, bouncy release.
        c  = cyc;
        p  = c + 6;
        d0 = p + 10;
        push(p, 2'b01, 2'b00, 2'b00, 2'b01, 1'b1);
        for (int k = 0; k < 5; k++) push(p + 6 + 3 * k, 2'b00, 2'b00, 2'b01, 2'b01, 1'b0);
        push(d0 + 10, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        tick(16);
        raw_btn_n = 2'b11; tick(1);
        raw_btn_n = 2'b10; tick(1);
        raw_btn_n = 2'b11; tick(1);
        raw_btn_n = 2'b10; tick(1);
        raw_btn_n = 2'b11; tick(12);
        check_drained("reset_restart_bounce_release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
